// File: rtl/async_fifo_wr_arb_if.sv
// async_fifo_wr_arb_if
// Bundles the two requester handshakes and the FIFO write port of the
// async FIFO write-side arbiter.
//   master : drives requests and wr_full (requesters + FIFO side model)
//   slave  : the arbiter; returns ready strobes, wr_inc/wr_data, busy, grant
interface async_fifo_wr_arb_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    req0_valid;
  logic [2*DATA_WIDTH-1:0] req0_data;
  logic                    req0_len;
  logic                    req0_ready;
  logic                    req1_valid;
  logic [2*DATA_WIDTH-1:0] req1_data;
  logic                    req1_len;
  logic                    req1_ready;
  logic                    wr_full;
  logic                    wr_inc;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    busy;
  logic                    grant;

  modport master (
    output req0_valid, req0_data, req0_len,
    output req1_valid, req1_data, req1_len,
    output wr_full,
    input  req0_ready, req1_ready, wr_inc, wr_data, busy, grant
  );

  modport slave (
    input  req0_valid, req0_data, req0_len,
    input  req1_valid, req1_data, req1_len,
    input  wr_full,
    output req0_ready, req1_ready, wr_inc, wr_data, busy, grant
  );
endinterface

// File: rtl/async_fifo_wr_arb.sv
// async_fifo_wr_arb
// Write-side arbiter/frame sequencer for an async FIFO write port (W_CLK
// domain). Two requesters submit 1- or 2-byte frames; one frame at a time is
// latched and serialized byte-by-byte onto wr_inc/wr_data, stalled by wr_full.
// Ports:
//   W_CLK : write clock, rising edge
//   W_RST : asynchronous active-low reset
//   bus   : async_fifo_wr_arb_if.slave (req0/req1 handshakes, FIFO port,
//           busy, grant)
// Configuration macro: ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins contention
//   undefined -> round-robin against the last granted requester
module async_fifo_wr_arb #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  async_fifo_wr_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] payload_q, payload_d;
  logic                    len_q, len_d;
  logic                    grant_q, grant_d;
`ifndef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
  logic                    last_grant_q, last_grant_d;
`endif

  logic                    win_s;
  logic                    accept_s;
  logic                    wr_inc_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;

  // Winner selection among valid requesters (only used when in IDLE).
  always_comb begin
    win_s = 1'b0;
`ifdef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
    win_s = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) begin
      win_s = ~last_grant_q;
    end else begin
      win_s = ~bus.req0_valid;
    end
`endif
  end

  // Frame sequencer: next state, latch updates and FIFO write strobe.
  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    len_d        = len_q;
    grant_d      = grant_q;
`ifndef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    accept_s     = 1'b0;
    wr_inc_s     = 1'b0;
    wr_data_s    = payload_q[DATA_WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept_s     = 1'b1;
          payload_d    = win_s ? bus.req1_data : bus.req0_data;
          len_d        = win_s ? bus.req1_len  : bus.req0_len;
          grant_d      = win_s;
`ifndef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
          last_grant_d = win_s;
`endif
          state_d      = BYTE0;
        end else begin
          state_d = IDLE;
        end
      end
      BYTE0: begin
        wr_inc_s = ~bus.wr_full;
        if (wr_inc_s) begin
          state_d = len_q ? BYTE1 : IDLE;
        end else begin
          state_d = BYTE0;
        end
      end
      BYTE1: begin
        wr_data_s = payload_q[2*DATA_WIDTH-1:DATA_WIDTH];
        wr_inc_s  = ~bus.wr_full;
        if (wr_inc_s) begin
          state_d = IDLE;
        end else begin
          state_d = BYTE1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and frame latch registers; last_grant resets to 1 so req0 wins first.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_q      <= IDLE;
      payload_q    <= '0;
      len_q        <= 1'b0;
      grant_q      <= 1'b0;
`ifndef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      payload_q    <= payload_d;
      len_q        <= len_d;
      grant_q      <= grant_d;
`ifndef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.req0_ready = accept_s & ~win_s;
  assign bus.req1_ready = accept_s &  win_s;
  assign bus.wr_inc     = wr_inc_s;
  assign bus.wr_data    = wr_data_s;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant      = grant_q;

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Testbench for async_fifo_wr_arb: directed scenarios plus a randomized run
// checked against a frame-level reference model (byte queue + remaining
// byte count + arbitration rule).
module tb_async_fifo_wr_arb;
  localparam int DW = 8;

  logic W_CLK = 1'b0;
  logic W_RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  async_fifo_wr_arb_if #(.DATA_WIDTH(DW)) bus ();

  async_fifo_wr_arb #(.DATA_WIDTH(DW)) dut (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .bus   (bus.slave)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic drive_pt();
    @(posedge W_CLK); #1;
  endtask

  task automatic sample_pt();
    @(negedge W_CLK);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_len = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_len = 1'b0;
    bus.wr_full    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 W_RST = 1'b0;
    drive_pt();
    drive_pt();
    W_RST = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    W_RST = 1'b0;
    #12;
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL reset_wr_inc got %b exp 0", bus.wr_inc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b exp 0", bus.grant); end
    checks++; if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h exp 00", bus.wr_data); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {bus.req0_ready, bus.req1_ready}); end
    drive_pt();
    W_RST = 1'b1;
  endtask

  task automatic test_single();
    drive_pt();
    bus.req0_valid = 1'b1; bus.req0_len = 1'b0; bus.req0_data = 16'h00A5;
    sample_pt();
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
    drive_pt();
    bus.req0_valid = 1'b0;
    sample_pt();
    checks++; if ({bus.wr_inc, bus.wr_data, bus.busy, bus.grant} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin errors++; $display("FAIL single_write got inc=%b data=%h busy=%b grant=%b exp 1 a5 1 0", bus.wr_inc, bus.wr_data, bus.busy, bus.grant); end
    drive_pt();
    sample_pt();
    checks++; if ({bus.busy, bus.wr_inc} !== 2'b00) begin errors++; $display("FAIL single_done got busy/inc=%b exp 00", {bus.busy, bus.wr_inc}); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b [2];
    exp_b[0] = 8'h5A; exp_b[1] = 8'h3C;
    drive_pt();
    bus.req1_valid = 1'b1; bus.req1_len = 1'b1; bus.req1_data = 16'h3C5A;
    sample_pt();
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL stall_ready got %b exp 01", {bus.req0_ready, bus.req1_ready}); end
    drive_pt();
    bus.req1_valid = 1'b0; bus.wr_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_pt();
      checks++; if ({bus.wr_inc, bus.busy, bus.grant} !== 3'b011) begin errors++; $display("FAIL stall_hold%0d got inc/busy/grant=%b exp 011", i, {bus.wr_inc, bus.busy, bus.grant}); end
      drive_pt();
    end
    bus.wr_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample_pt();
      checks++; if ({bus.wr_inc, bus.wr_data, bus.grant} !== {1'b1, exp_b[i], 1'b1}) begin errors++; $display("FAIL stall_byte%0d got inc=%b data=%h grant=%b exp 1 %h 1", i, bus.wr_inc, bus.wr_data, bus.grant, exp_b[i]); end
      drive_pt();
    end
    sample_pt();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_done got busy=%b exp 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b [4];
    logic [7:0] got_b [$];
    int         cyc;
`ifdef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
    exp_b[0] = 8'h11; exp_b[1] = 8'h11; exp_b[2] = 8'h11; exp_b[3] = 8'h11;
`else
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h11; exp_b[3] = 8'h22;
`endif
    drive_pt();
    bus.req0_valid = 1'b1; bus.req0_len = 1'b0; bus.req0_data = 16'hFF11;
    bus.req1_valid = 1'b1; bus.req1_len = 1'b0; bus.req1_data = 16'hEE22;
    cyc = 0;
    while (got_b.size() < 4 && cyc < 40) begin
      sample_pt();
      checks++; if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin errors++; $display("FAIL rr_one_ready got 11 exp at most one"); end
      if (bus.wr_inc === 1'b1) got_b.push_back(bus.wr_data);
      drive_pt();
      cyc++;
    end
    checks++; if (got_b.size() != 4) begin errors++; $display("FAIL rr_timeout got %0d writes exp 4", got_b.size()); end
    for (int i = 0; i < got_b.size(); i++) begin
      checks++; if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL rr_order%0d got %h exp %h", i, got_b[i], exp_b[i]); end
    end
    // req0 backs off: req1 must now be served
    bus.req0_valid = 1'b0;
    sample_pt();
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL rr_req1_after got %b exp 01", {bus.req0_ready, bus.req1_ready}); end
    drive_pt();
    bus.req1_valid = 1'b0;
    sample_pt();
    checks++; if ({bus.wr_inc, bus.wr_data} !== {1'b1, 8'h22}) begin errors++; $display("FAIL rr_req1_write got %b %h exp 1 22", bus.wr_inc, bus.wr_data); end
    drive_pt();
  endtask

  task automatic test_no_interleave();
    drive_pt();
    bus.req0_valid = 1'b1; bus.req0_len = 1'b1; bus.req0_data = 16'hBBAA;
    sample_pt();
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL ni_accept got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
    drive_pt();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_len = 1'b0; bus.req1_data = 16'h00CC;
    sample_pt();
    checks++; if ({bus.wr_inc, bus.wr_data, bus.req1_ready} !== {1'b1, 8'hAA, 1'b0}) begin errors++; $display("FAIL ni_byte0 got inc=%b data=%h r1=%b exp 1 aa 0", bus.wr_inc, bus.wr_data, bus.req1_ready); end
    drive_pt();
    sample_pt();
    checks++; if ({bus.wr_inc, bus.wr_data, bus.req1_ready} !== {1'b1, 8'hBB, 1'b0}) begin errors++; $display("FAIL ni_byte1 got inc=%b data=%h r1=%b exp 1 bb 0", bus.wr_inc, bus.wr_data, bus.req1_ready); end
    drive_pt();
    sample_pt();
    checks++; if ({bus.req1_ready, bus.busy, bus.wr_inc} !== 3'b100) begin errors++; $display("FAIL ni_req1_accept got r1/busy/inc=%b exp 100", {bus.req1_ready, bus.busy, bus.wr_inc}); end
    drive_pt();
    bus.req1_valid = 1'b0;
    sample_pt();
    checks++; if ({bus.wr_inc, bus.wr_data} !== {1'b1, 8'hCC}) begin errors++; $display("FAIL ni_req1_write got %b %h exp 1 cc", bus.wr_inc, bus.wr_data); end
    drive_pt();
  endtask

  task automatic test_reset_mid_frame();
    drive_pt();
    bus.req1_valid = 1'b1; bus.req1_len = 1'b1; bus.req1_data = 16'h7766;
    sample_pt();
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL rm_accept got %b exp 1", bus.req1_ready); end
    drive_pt();
    bus.req1_valid = 1'b0;
    sample_pt();
    checks++; if ({bus.wr_inc, bus.wr_data} !== {1'b1, 8'h66}) begin errors++; $display("FAIL rm_byte0 got %b %h exp 1 66", bus.wr_inc, bus.wr_data); end
    drive_pt();
    bus.wr_full = 1'b1;
    sample_pt();
    checks++; if ({bus.busy, bus.grant, bus.wr_inc} !== 3'b110) begin errors++; $display("FAIL rm_in_byte1 got busy/grant/inc=%b exp 110", {bus.busy, bus.grant, bus.wr_inc}); end
    #2 W_RST = 1'b0;
    #1;
    checks++; if ({bus.wr_inc, bus.busy, bus.grant} !== 3'b000) begin errors++; $display("FAIL rm_async got inc/busy/grant=%b exp 000", {bus.wr_inc, bus.busy, bus.grant}); end
    drive_pt();
    bus.wr_full = 1'b0;
    drive_pt();
    W_RST = 1'b1;
    sample_pt();
    checks++; if ({bus.wr_inc, bus.busy, bus.req0_ready, bus.req1_ready} !== 4'b0000) begin errors++; $display("FAIL rm_discard got inc/busy/r0/r1=%b exp 0000", {bus.wr_inc, bus.busy, bus.req0_ready, bus.req1_ready}); end
    drive_pt();
    bus.req0_valid = 1'b1; bus.req0_len = 1'b0; bus.req0_data = 16'h0033;
    bus.req1_valid = 1'b1; bus.req1_len = 1'b0; bus.req1_data = 16'h0044;
    sample_pt();
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL rm_first_contention got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
    drive_pt();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    sample_pt();
    checks++; if ({bus.wr_inc, bus.wr_data, bus.grant} !== {1'b1, 8'h33, 1'b0}) begin errors++; $display("FAIL rm_first_write got %b %h %b exp 1 33 0", bus.wr_inc, bus.wr_data, bus.grant); end
    drive_pt();
  endtask

  // Randomized run against a frame-level model: remaining-byte count,
  // expected byte queue, last winner and the arbitration rule.
  task automatic test_random();
    logic        pend [2];
    logic [15:0] pdata [2];
    logic        plen [2];
    logic [7:0]  m_bytes [$];
    int          m_rem;
    logic        m_last, m_grant, win, acc, full;
    logic        exp_r0, exp_r1, exp_inc, exp_busy;
    do_reset();
    m_rem = 0; m_last = 1'b1; m_grant = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r]  = 1'b1;
          pdata[r] = 16'($urandom);
          plen[r]  = 1'($urandom_range(0, 1));
        end
      end
      full = ($urandom_range(0, 3) == 0);
      bus.req0_valid = pend[0]; bus.req0_data = pdata[0]; bus.req0_len = plen[0];
      bus.req1_valid = pend[1]; bus.req1_data = pdata[1]; bus.req1_len = plen[1];
      bus.wr_full    = full;
      acc = (m_rem == 0) && (pend[0] || pend[1]);
`ifdef ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN
      win = pend[0] ? 1'b0 : 1'b1;
`else
      if (pend[0] && pend[1]) win = ~m_last;
      else win = pend[0] ? 1'b0 : 1'b1;
`endif
      exp_r0   = acc && !win;
      exp_r1   = acc && win;
      exp_inc  = (m_rem > 0) && !full;
      exp_busy = (m_rem > 0);
      sample_pt();
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {exp_r0, exp_r1}) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, {bus.req0_ready, bus.req1_ready}, {exp_r0, exp_r1}); end
      checks++; if ({bus.wr_inc, bus.busy, bus.grant} !== {exp_inc, exp_busy, m_grant}) begin errors++; $display("FAIL rnd_ctrl c%0d got inc/busy/grant=%b exp %b", c, {bus.wr_inc, bus.busy, bus.grant}, {exp_inc, exp_busy, m_grant}); end
      if (exp_inc && m_bytes.size() > 0) begin
        checks++; if (bus.wr_data !== m_bytes[0]) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", c, bus.wr_data, m_bytes[0]); end
        void'(m_bytes.pop_front());
        m_rem--;
      end
      if (acc) begin
        m_bytes.push_back(pdata[win][7:0]);
        if (plen[win]) m_bytes.push_back(pdata[win][15:8]);
        m_rem   = plen[win] ? 2 : 1;
        m_grant = win;
        m_last  = win;
        pend[win] = 1'b0;
      end
      drive_pt();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_stall();
    test_round_robin();
    test_no_interleave();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_arb.md
# async_fifo_wr_arb

Write-side arbiter and frame sequencer for the asynchronous FIFO write port in the W_CLK domain. It shares the single FIFO write port between two requesters, each submitting 1- or 2-byte frames. Frames are serialized byte-by-byte into `wr_inc`/`wr_data` and held off by `wr_full`. Bytes of different frames are never interleaved.

## Interface
- `DATA_WIDTH`, default 8: FIFO byte width.
- `W_CLK` input 1: write-domain clock, rising edge.
- `W_RST` input 1: reset, asynchronous, active-low.
- `req0_valid` input 1: requester 0 has a frame pending.
- `req0_data` input 2*DATA_WIDTH: frame payload; byte0 = `[DATA_WIDTH-1:0]`, byte1 = upper half.
- `req0_len` input 1: frame length; 0 = 1 byte, 1 = 2 bytes.
- `req0_ready` output 1: frame accepted this cycle.
- `req1_valid`, `req1_data`, `req1_len`, `req1_ready`: same as requester 0, for requester 1.
- `wr_full` input 1: FIFO full flag, already in the W_CLK domain.
- `wr_inc` output 1: FIFO write strobe.
- `wr_data` output DATA_WIDTH: FIFO write data.
- `busy` output 1: a frame is latched and not yet fully written.
- `grant` output 1: index of the requester owning the current or last frame.

## Operation
- FSM states: IDLE, BYTE0, BYTE1. Encoding is free.
- **IDLE**
  - If any `reqN_valid` is high, select a winner and assert `reqN_ready` combinationally for the winner only.
  - On that edge: latch payload and length, set `grant` = winner, go to BYTE0.
  - If no valid: stay in IDLE.
- **Round-robin selection**
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to `last_grant` wins.
  - `last_grant` updates on every acceptance.
- **BYTE0**
  - `wr_data` = latched byte0.
  - `wr_inc` = ~`wr_full` (combinational).
  - On an edge with `wr_inc` high: go to BYTE1 if latched len = 1, else go to IDLE.
  - While `wr_full` is high: hold state and data.
- **BYTE1**: same as BYTE0 using latched byte1; always returns to IDLE after the write.
- `busy` = state ≠ IDLE.
- Requests arriving while busy are not acknowledged; requesters must hold `valid`/`data`/`len` stable until `ready`.
- Payload bits above DATA_WIDTH are ignored when len = 0.
- `wr_inc` is never high in IDLE, so there are no spurious writes.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = 1 (requester 0 wins the first contention).
  - `grant` = 0, `busy` = 0, `wr_inc` = 0, `wr_data` = 0.
  - Latched payload = 0; both `req_ready` = 0.
- Accept-to-first-write latency: 1 cycle (accept at edge k, byte0 written at edge k+1 if not full).
- Throughput:
  - 1-byte frame: 2 cycles.
  - 2-byte frame: 3 cycles.
  - Back-to-back frames have one IDLE cycle between them.
- `wr_full` asserted mid-frame stalls in the current byte state; writing resumes on the first cycle `wr_full` is low, with no byte lost or duplicated.
- `req_ready` is high for exactly one cycle per accepted frame; at most one `ready` is high per cycle.
- Reset asserted mid-frame: all state returns to reset values immediately (async). The remaining bytes of the frame are discarded, and the requester is not re-acknowledged.
- `wr_full` in IDLE does not block acceptance; the frame waits in BYTE0.

## Configuration
- Macro: `ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority. Requester 0 always wins when both are valid; `last_grant` is unused, but `grant` still reports the owner.
- Undefined (default): round-robin as described under Operation.

## Test plan
- **Single 1-byte frame:** after reset, req0 valid, len=0, data=0x00A5, `wr_full`=0 → `req0_ready` pulses at cycle 0, `wr_inc`=1 with `wr_data`=0xA5 at cycle 1, `busy` drops at cycle 2.
- **2-byte frame with stall:** req1 len=1, data=0x3C5A; `wr_full`=1 for 3 cycles after accept → `wr_inc` stays 0 for 3 cycles, then 0x5A, then 0x3C on consecutive cycles; `grant`=1 throughout.
- **Contention, round-robin:** both valid continuously, 1-byte frames 0x11 (req0) and 0x22 (req1) → write order 0x11, 0x22, 0x11, 0x22; never two `ready` pulses in one cycle.
- **No interleave:** req0 2-byte frame 0xBBAA accepted, req1 asserts valid during BYTE0 → FIFO sees 0xAA, 0xBB, then req1's byte; `req1_ready` stays low until IDLE.
- **Reset mid-frame:** assert `W_RST` low while in BYTE1 with `wr_full`=1 → `wr_inc`, `busy`, `grant` go to 0 asynchronously; after release, `last_grant`=1 and the next contention is won by req0.
- **Fixed-priority build:** with `ASYNC_FIFO_WR_ARB_FIXED_PRIO_EN` defined and both valid for 4 frames → all 4 grants go to req0; req1 is served only after req0 deasserts.
